// File: rtl/gf128_mul_ds.sv
// Digit-serial carry-less 128x128 multiplier (GHASH), DIGIT bits of b per cycle, MSB-first.
// Define GF128_MUL_REDUCE_EN to add the mod (x^128+x^7+x^2+x+1) result on port r.
module gf128_mul_ds #(
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [255:0] p
`ifdef GF128_MUL_REDUCE_EN
    ,
    output logic [127:0] r
`endif
);

    localparam int NCYC = 128 / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
          DIGIT == 16 || DIGIT == 32 || DIGIT == 64 || DIGIT == 128)) begin : g_bad_digit
        $error("gf128_mul_ds: DIGIT must be a power of two dividing 128");
    end

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state_q, state_d;
    logic [127:0]    a_q, a_d;
    logic [127:0]    b_q, b_d;
    logic [255:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [255:0]    p_q, p_d;
    logic [255:0]    acc_nxt;

    function automatic logic [255:0] clmul_digit(input logic [127:0] av,
                                                 input logic [DIGIT-1:0] d);
        logic [255:0] res;
        res = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (d[j]) res = res ^ ({128'b0, av} << j);
        end
        return res;
    endfunction

`ifdef GF128_MUL_REDUCE_EN
    logic [127:0] r_q, r_d;

    // Two folds of the upper half: the first leaves at most 7 bits above x^127.
    function automatic logic [127:0] gf_reduce(input logic [254:0] v);
        logic [134:0] t;
        logic [6:0]   h2;
        t = {7'b0, v[127:0]} ^ {8'b0, v[254:128]} ^ {7'b0, v[254:128], 1'b0}
          ^ {6'b0, v[254:128], 2'b0} ^ {1'b0, v[254:128], 7'b0};
        h2 = t[134:128];
        return t[127:0] ^ {121'b0, h2} ^ {120'b0, h2, 1'b0}
             ^ {119'b0, h2, 2'b0} ^ {114'b0, h2, 7'b0};
    endfunction

    assign r = r_q;
`endif

    assign p       = p_q;
    assign acc_nxt = (acc_q << DIGIT) ^ clmul_digit(a_q, b_q[127 -: DIGIT]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
`ifdef GF128_MUL_REDUCE_EN
            r_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef GF128_MUL_REDUCE_EN
            r_q     <= r_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
`ifdef GF128_MUL_REDUCE_EN
        r_d       = r_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                busy  = 1'b1;
                acc_d = acc_nxt;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    p_d     = acc_nxt;
`ifdef GF128_MUL_REDUCE_EN
                    r_d     = gf_reduce(acc_nxt[254:0]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gf128_mul_ds.sv
// Scoreboard bench for gf128_mul_ds at DIGIT = 4, 1, 8, 128 (one instance each).
module tb_gf128_mul_ds;

    localparam int NI = 4;
    localparam int DIG [NI] = '{4, 1, 8, 128};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_v  [NI];
    logic         in_ready_v  [NI];
    logic [127:0] a_v         [NI];
    logic [127:0] b_v         [NI];
    logic         out_valid_v [NI];
    logic         out_ready_v [NI];
    logic         busy_v      [NI];
    logic [255:0] p_v         [NI];
`ifdef GF128_MUL_REDUCE_EN
    logic [127:0] r_v         [NI];
    logic [127:0] expr_q [$];
`endif
    logic [255:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gf128_mul_ds #(.DIGIT(DIG[g])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_v[g]),
            .in_ready (in_ready_v[g]),
            .a        (a_v[g]),
            .b        (b_v[g]),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready_v[g]),
            .busy     (busy_v[g]),
            .p        (p_v[g])
`ifdef GF128_MUL_REDUCE_EN
            ,
            .r        (r_v[g])
`endif
        );
    end

    function automatic logic [255:0] clmul_ref(input logic [127:0] x, input logic [127:0] y);
        logic [255:0] s;
        s = '0;
        for (int i = 0; i < 128; i++) if (y[i]) s = s ^ ({128'b0, x} << i);
        return s;
    endfunction

    function automatic logic [127:0] mod_ref(input logic [255:0] v);
        logic [255:0] t;
        logic [255:0] poly;
        t    = v;
        poly = {127'b0, 1'b1, 128'h87};
        for (int i = 255; i >= 128; i--) if (t[i]) t = t ^ (poly << (i - 128));
        return t[127:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_exp(input logic [127:0] x, input logic [127:0] y);
        exp_q.push_back(clmul_ref(x, y));
`ifdef GF128_MUL_REDUCE_EN
        expr_q.push_back(mod_ref(clmul_ref(x, y)));
`endif
    endtask

    task automatic flush_exp();
        exp_q.delete();
`ifdef GF128_MUL_REDUCE_EN
        expr_q.delete();
`endif
    endtask

    // One full transaction on instance k with latency and scoreboard checks.
    task automatic do_op(input int k, input logic [127:0] x, input logic [127:0] y);
        int t0, n;
        logic [255:0] ep;
        @(negedge clk);
        n_cmp++;
        if (in_ready_v[k] !== 1'b1) begin
            n_err++; $display("FAIL idle_ready[%0d]: got %b want 1", k, in_ready_v[k]);
        end
        a_v[k] = x; b_v[k] = y; in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b1;
        push_exp(x, y);
        @(negedge clk);
        t0 = cyc;
        in_valid_v[k] = 1'b0; a_v[k] = ~x; b_v[k] = rnd128();
        n = 0;
        while (out_valid_v[k] !== 1'b1 && n < 300) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (out_valid_v[k] !== 1'b1) begin
            n_err++; $display("FAIL timeout[%0d]: out_valid never rose", k);
            flush_exp();
            return;
        end
        if (cyc - t0 !== 128 / DIG[k]) begin
            n_err++; $display("FAIL latency[%0d]: got %0d want %0d", k, cyc - t0, 128 / DIG[k]);
        end
        ep = exp_q.pop_front();
        n_cmp++;
        if (p_v[k] !== ep) begin
            n_err++; $display("FAIL p[%0d]: got %h want %h", k, p_v[k], ep);
        end
`ifdef GF128_MUL_REDUCE_EN
        begin
            logic [127:0] er;
            er = expr_q.pop_front();
            n_cmp++;
            if (r_v[k] !== er) begin
                n_err++; $display("FAIL r[%0d]: got %h want %h", k, r_v[k], er);
            end
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
            n_err++; $display("FAIL handshake_done[%0d]: out_valid=%b in_ready=%b want 0/1",
                              k, out_valid_v[k], in_ready_v[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0 || busy_v[k] !== 1'b0 ||
                p_v[k] !== '0) begin
                n_err++;
                $display("FAIL reset[%0d]: rdy=%b ov=%b busy=%b p=%h want 1/0/0/0",
                         k, in_ready_v[k], out_valid_v[k], busy_v[k], p_v[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        do_op(0, 128'h1, 128'h1);
        n_cmp++;
        if (p_v[0] !== 256'h1) begin
            n_err++; $display("FAIL identity_p: got %h want 1", p_v[0]);
        end
`ifdef GF128_MUL_REDUCE_EN
        n_cmp++;
        if (r_v[0] !== 128'h1) begin
            n_err++; $display("FAIL identity_r: got %h want 1", r_v[0]);
        end
`endif
    endtask

    task automatic test_top_degree();
        logic [255:0] e;
        e = '0; e[254] = 1'b1;
        do_op(0, {1'b1, 127'b0}, {1'b1, 127'b0});
        n_cmp++;
        if (p_v[0] !== e) begin
            n_err++; $display("FAIL top_p254: got %h want %h", p_v[0], e);
        end
        e = '0; e[128] = 1'b1;
        do_op(0, {1'b1, 127'b0}, 128'h2);
        n_cmp++;
        if (p_v[0] !== e) begin
            n_err++; $display("FAIL top_p128: got %h want %h", p_v[0], e);
        end
`ifdef GF128_MUL_REDUCE_EN
        n_cmp++;
        if (r_v[0] !== 128'h87) begin
            n_err++; $display("FAIL top_r87: got %h want 87", r_v[0]);
        end
`endif
    endtask

    task automatic test_random(input int k, input int count);
        do_op(k, '1, '1);
        for (int i = 0; i < count; i++) do_op(k, rnd128(), rnd128());
    endtask

    task automatic test_backpressure();
        int n;
        logic [255:0] held;
        out_ready_v[0] = 1'b0;
        @(negedge clk);
        a_v[0] = rnd128(); b_v[0] = rnd128(); in_valid_v[0] = 1'b1;
        push_exp(a_v[0], b_v[0]);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        n = 0;
        while (out_valid_v[0] !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        held = exp_q.pop_front();
`ifdef GF128_MUL_REDUCE_EN
        void'(expr_q.pop_front());
`endif
        n_cmp++;
        if (out_valid_v[0] !== 1'b1 || p_v[0] !== held) begin
            n_err++; $display("FAIL bp_result: ov=%b p=%h want 1/%h", out_valid_v[0], p_v[0], held);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid_v[0] = (i >= 3 && i < 6);
            a_v[0] = rnd128(); b_v[0] = rnd128();
            @(negedge clk);
            n_cmp++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || p_v[0] !== held) begin
                n_err++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b p=%h want 1/0/%h",
                         i, out_valid_v[0], in_ready_v[0], p_v[0], held);
            end
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            n_err++; $display("FAIL bp_release: ov=%b rdy=%b busy=%b want 0/1/0",
                              out_valid_v[0], in_ready_v[0], busy_v[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_v[0] !== 1'b0 || p_v[0] !== held) begin
            n_err++; $display("FAIL bp_retain: busy=%b p=%h want 0/%h", busy_v[0], p_v[0], held);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        do_op(0, rnd128(), rnd128() | 128'h1);
        @(negedge clk);
        a_v[0] = rnd128(); b_v[0] = rnd128(); in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 ||
            p_v[0] !== '0) begin
            n_err++; $display("FAIL midrst_state: rdy=%b ov=%b busy=%b p=%h want 1/0/0/0",
                              in_ready_v[0], out_valid_v[0], busy_v[0], p_v[0]);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back(input int k);
        int acc_cyc [3];
        int out_cyc [3];
        int idx, got;
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        a_v[k] = rnd128(); b_v[k] = rnd128(); in_valid_v[k] = 1'b1;
        push_exp(a_v[k], b_v[k]);
        idx = 0; got = 0;
        fork
            begin
                int guard;
                logic rdy;
                guard = 0;
                while (idx < 3 && guard < 600) begin
                    rdy = in_ready_v[k];
                    @(negedge clk); guard++;
                    if (rdy) begin
                        acc_cyc[idx] = cyc;
                        idx++;
                        if (idx < 3) begin
                            a_v[k] = rnd128(); b_v[k] = rnd128();
                            push_exp(a_v[k], b_v[k]);
                        end else in_valid_v[k] = 1'b0;
                    end
                end
                in_valid_v[k] = 1'b0;
            end
            begin
                int guard;
                logic [255:0] ep;
                guard = 0;
                while (got < 3 && guard < 700) begin
                    @(negedge clk); guard++;
                    if (out_valid_v[k] === 1'b1) begin
                        out_cyc[got] = cyc;
                        ep = exp_q.pop_front();
                        n_cmp++;
                        if (p_v[k] !== ep) begin
                            n_err++; $display("FAIL b2b_p[%0d.%0d]: got %h want %h", k, got, p_v[k], ep);
                        end
`ifdef GF128_MUL_REDUCE_EN
                        begin
                            logic [127:0] er;
                            er = expr_q.pop_front();
                            n_cmp++;
                            if (r_v[k] !== er) begin
                                n_err++; $display("FAIL b2b_r[%0d.%0d]: got %h want %h", k, got, r_v[k], er);
                            end
                        end
`endif
                        got++;
                    end
                end
            end
        join
        n_cmp++;
        if (got !== 3) begin
            n_err++; $display("FAIL b2b_count[%0d]: got %0d results want 3", k, got);
            flush_exp();
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (out_cyc[i] - acc_cyc[i] !== 128 / DIG[k]) begin
                    n_err++; $display("FAIL b2b_latency[%0d.%0d]: got %0d want %0d",
                                      k, i, out_cyc[i] - acc_cyc[i], 128 / DIG[k]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (out_cyc[i] - out_cyc[i-1] !== 128 / DIG[k] + 2) begin
                        n_err++; $display("FAIL b2b_spacing[%0d.%0d]: got %0d want %0d",
                                          k, i, out_cyc[i] - out_cyc[i-1], 128 / DIG[k] + 2);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0;
        end
        rst_n = 1'b0;
        test_reset();
        test_identity();
        test_top_degree();
        test_random(0, 200);
        test_random(1, 30);
        test_random(2, 100);
        test_random(3, 200);
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back(0);
        test_back_to_back(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
